// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain: STAGES flops deep, bubbles collapse, flush clears.
// Latency: an entry accepted on edge k is presented after edge k+STAGES-1.
// Backpressure: in_ready follows out_ready combinationally through the advance chain; no skid storage.
module pipe_reg_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0] count
);

  localparam int CW = $clog2(STAGES + 1);

  // Stage 0 is the input side, stage STAGES-1 drives the output.
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // adv[i]: stage i hands its entry downstream this cycle.
  // sink_ok[i]: stage i can take a new entry (empty or emptying);
  // sink_ok[STAGES] is the downstream consumer.
  logic [STAGES-1:0] adv;
  logic [STAGES:0]   sink_ok;
  logic [STAGES-1:0] hand;
  logic [WIDTH-1:0]  up_dat [STAGES];
  logic              kill;
  logic              in_xfer;
  logic [CW-1:0]     count_c;

  // Reset also masks the handshake so no transfer is reported on a reset edge.
  assign kill    = flush | reset;
  assign in_ready  = sink_ok[0] & ~kill;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = valid_q[STAGES-1] & ~kill;
  assign out_data  = data_q[STAGES-1];
  assign count     = count_c;

  // Advance chain, evaluated from the output side back toward the input.
  always_comb begin
    adv     = '0;
    sink_ok = '0;
    sink_ok[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i]     = valid_q[i] & sink_ok[i+1] & ~kill;
      sink_ok[i] = ~valid_q[i] | adv[i];
    end
  end

  // Hand-over into each stage: input transfer for stage 0, advance of the previous stage otherwise.
  always_comb begin
    hand      = '0;
    hand[0]   = in_xfer;
    up_dat[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      hand[i]   = adv[i-1];
      up_dat[i] = data_q[i-1];
    end
  end

  // Next state: load on hand-over, empty on advance without load, clear all valids on flush.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
      if (hand[i]) begin
        data_d[i]  = up_dat[i];
        valid_d[i] = 1'b1;
      end else if (adv[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // State registers; data flops only change on load so stale payload is retained in empty stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Occupancy is a popcount of the registered valids only.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_c = count_c + CW'(valid_q[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=8, STAGES=3): directed scenarios plus random traffic,
// every cycle compared against a queue-of-entries reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipe_reg_chain;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int CW     = $clog2(STAGES + 1);

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight entries oldest first, each with its stage position.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] last_out   = '0;
  bit               model_known = 1'b0;

  logic             obs_ir, obs_ov;
  logic [WIDTH-1:0] obs_od;
  logic [CW-1:0]    obs_cnt;

  // One clock cycle: apply inputs, sample and check at negedge, advance model, then pass the edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [WIDTH-1:0] id, input logic ordy);
    bit   mv[$];
    bit   m;
    bit   kill;
    bit   e_ir, e_ov;
    ent_t e;
    ent_t nq[$];
    reset = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
    obs_ir = in_ready; obs_ov = out_valid; obs_od = out_data; obs_cnt = count;
    kill = r | f;
    mv = {};
    for (int i = 0; i < mq.size(); i++) begin
      if (kill) m = 1'b0;
      else if (mq[i].pos == STAGES - 1) m = ordy;
      else if (i == 0) m = 1'b1;
      else m = (mq[i-1].pos != mq[i].pos + 1) || mv[i-1];
      mv.push_back(m);
    end
    e_ir = !kill && (mq.size() == 0 || mq[mq.size()-1].pos != 0 || mv[mq.size()-1]);
    e_ov = !kill && mq.size() > 0 && mq[0].pos == STAGES - 1;
    if (model_known) begin
      check_eq("in_ready",  32'(obs_ir),  32'(e_ir));
      check_eq("out_valid", 32'(obs_ov),  32'(e_ov));
      check_eq("count",     32'(obs_cnt), 32'(mq.size()));
      check_eq("out_data",  32'(obs_od),  32'(last_out));
    end
    if (r) begin
      mq.delete();
      last_out    = '0;
      model_known = 1'b1;
    end else if (f) begin
      mq.delete();
    end else begin
      nq = {};
      for (int i = 0; i < mq.size(); i++) begin
        if (mv[i]) begin
          if (mq[i].pos != STAGES - 1) begin
            e = mq[i];
            e.pos++;
            if (e.pos == STAGES - 1) last_out = e.d;
            nq.push_back(e);
          end
        end else begin
          nq.push_back(mq[i]);
        end
      end
      if (iv && e_ir) begin
        e.d = id; e.pos = 0;
        nq.push_back(e);
        if (STAGES == 1) last_out = id;
      end
      mq = nq;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with junk on the other inputs, then release.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("rst_out_valid", 32'(obs_ov),  32'd0);
    check_eq("rst_out_data",  32'(obs_od),  32'd0);
    check_eq("rst_count",     32'(obs_cnt), 32'd0);
    check_eq("rst_in_ready",  32'(obs_ir),  32'd1);

    // Streaming: four back-to-back entries, first output two cycles after acceptance.
    step(1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
    check_eq("stream_first_vld",  32'(obs_ov), 32'd1);
    check_eq("stream_first_data", 32'(obs_od), 32'h11);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("stream_second", 32'(obs_od), 32'h22);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("stream_third", 32'(obs_od), 32'h33);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("stream_fourth", 32'(obs_od), 32'h44);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("stream_drained", 32'(obs_ov), 32'd0);

    // Stall and collapse: A1, gap, A2 with the output blocked.
    step(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("collapse_count", 32'(obs_cnt), 32'd2);
    check_eq("collapse_ir",    32'(obs_ir),  32'd1);
    step(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0);
    check_eq("full_count", 32'(obs_cnt), 32'd3);
    check_eq("full_ir",    32'(obs_ir),  32'd0);

    // Full pass-through: held A4 goes first, then fresh data; occupancy stays at 3.
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b0, 1'b1, (j == 0) ? 8'hA4 : 8'(8'hB0 + j), 1'b1);
      check_eq("pass_count", 32'(obs_cnt), 32'd3);
      check_eq("pass_ir",    32'(obs_ir),  32'd1);
      if (j < 3) check_eq("pass_order", 32'(obs_od), 32'(8'hA1 + j));
    end

    // Drain, then load two entries for the flush case.
    for (int j = 0; j < 10 && mq.size() > 0; j++)
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("drain_empty", 32'(mq.size()), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
    check_eq("flush_ir", 32'(obs_ir), 32'd0);
    check_eq("flush_ov", 32'(obs_ov), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    check_eq("flush_count", 32'(obs_cnt), 32'd0);
    seen = 1'b0;
    for (int j = 0; j < 8 && !seen; j++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (obs_ov) begin
        seen = 1'b1;
        check_eq("flush_first_out", 32'(obs_od), 32'h5A);
      end
    end
    if (!seen) check_eq("flush_out_timeout", 32'd0, 32'd1);

    // Reset mid-operation on a full chain.
    step(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hD2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hD3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hD4, 1'b1);
    check_eq("midrst_ov", 32'(obs_ov), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("midrst_count", 32'(obs_cnt), 32'd0);
    check_eq("midrst_data",  32'(obs_od),  32'd0);
    check_eq("midrst_ov2",   32'(obs_ov),  32'd0);

    // Random traffic with occasional flush and reset.
    for (int j = 0; j < 2000; j++) begin
      step(($urandom_range(127) == 0), ($urandom_range(31) == 0),
           ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
